hit_detector: RTL
=================

# hit_detector

Generates the `damage_in` stimulus that the health bar consumes. It watches the per-pixel sprite flags from the player and hazard renderers and latches any overlap inside the active area. At the end of each frame, a latched overlap produces one clean damage pulse. An invulnerability window follows each hit, during which the player blinks, so every hit gives exactly one rising edge downstream. It sits between the sprite renderers and the health bar, and it freezes when the game is over.

## Interface
Parameters:
- `ACTIVE_H`, 1280, active pixels per line; overlaps are counted only when `hcount_in < ACTIVE_H`.
- `ACTIVE_V`, 720, active lines; overlaps are counted only when `vcount_in < ACTIVE_V`.
- `PULSE_CYCLES`, 4, width of `damage_out` in clocks, range 1..255.
- `INVULN_FRAMES`, 60, frames of invulnerability after a pulse, range 1..255.
- `BLINK_FRAMES`, 8, frames per blink half-period while invulnerable, range 1..255.

Ports:
- `clk` in 1: pixel clock.
- `rst` in 1: synchronous, active-high reset.
- `hcount_in` in 11: current pixel x.
- `vcount_in` in 10: current pixel y.
- `player_in_sprite` in 1: player sprite covers the current pixel.
- `hazard_in_sprite` in 1: any hazard sprite covers the current pixel.
- `game_over_in` in 1: level from the health bar's game-over output.
- `damage_out` out 1: damage pulse, connects to the health bar `damage_in`.
- `invuln_out` out 1: high while in PULSE or COOLDOWN.
- `player_visible_out` out 1: gates player sprite drawing, used for blinking.
- `hit_count_out` out 3: hits issued, saturating at 7.

## Operation
- Frame boundary (`fb`) is the single cycle where `hcount_in == 0 && vcount_in == ACTIVE_V`.
- Overlap occurs when `player_in_sprite && hazard_in_sprite` are both high inside the active area. `fb` is in blanking and never counts as an overlap.
- States:
  - **ARMED**:
    - An overlap sets `hit_latched`.
    - On `fb` with `hit_latched`: go to PULSE, load the pulse counter with `PULSE_CYCLES`, increment `hit_count_out` (saturating at 7), and clear `hit_latched`.
    - On `fb` without `hit_latched`: stay in ARMED.
  - **PULSE**:
    - `damage_out` = 1.
    - The pulse counter decrements each cycle.
    - When the counter reaches 0, go to COOLDOWN, load the frame counter with `INVULN_FRAMES`, clear the blink counter, and set `player_visible_out` = 0.
    - Overlaps are ignored.
  - **COOLDOWN**:
    - Overlaps are ignored and `hit_latched` is held at 0.
    - Each `fb` decrements the frame counter.
    - Each `fb` also advances the blink counter, which counts 0..`BLINK_FRAMES`-1. When it wraps, `player_visible_out` toggles.
    - The `fb` that takes the frame counter 1→0 returns the block to ARMED with `player_visible_out` = 1.
  - **DEAD**:
    - Entered from any state on the cycle after `game_over_in` = 1.
    - `damage_out` = 0, `invuln_out` = 0, `player_visible_out` = 1, `hit_count_out` holds.
    - Exited only by `rst`.
- Priority, highest first:
  1. `rst`
  2. `game_over_in` (a pending hit at the same `fb` is dropped, with no pulse)
  3. state logic
- Widths:
  - Pulse counter: 8 bits.
  - Frame and blink counters: 8 bits each.
  - `hit_count_out` never wraps past 7.

## Timing
- All outputs are registered.
- Reset values:
  - state ARMED
  - `damage_out` 0
  - `invuln_out` 0
  - `player_visible_out` 1
  - `hit_count_out` 0
  - `hit_latched` 0
  - all counters 0
- `damage_out` rises on the cycle after `fb` and stays high for exactly `PULSE_CYCLES` cycles. `invuln_out` rises in the same cycle.
- Pulses are always separated by at least `INVULN_FRAMES` frames of low level, so the health bar's edge detector sees one rising edge per hit.
- An overlap latched in frame N is reported at the `fb` that ends frame N, so the worst-case latency is one frame plus one clock.
- An overlap on the first ARMED cycle after COOLDOWN counts.
- `rst` mid-PULSE drops `damage_out` on the next cycle.

## Test plan
- Reset: assert `rst` for 2 cycles → `damage_out` = 0, `invuln_out` = 0, `player_visible_out` = 1, `hit_count_out` = 0.
- Single hit: overlap for one pixel at (100,100) in frame 0; `fb` at cycle T → `damage_out` high for T+1..T+4, `hit_count_out` = 1, `invuln_out` = 1. With `INVULN_FRAMES` = 3, overlaps injected in the next 3 frames cause no pulse, `invuln_out` falls on the cycle after the 3rd `fb`, and an overlap in the following frame gives `hit_count_out` = 2.
- Out-of-area overlap: both sprite flags high at `hcount_in` = 1300 or `vcount_in` = 730 → no pulse across 3 frames.
- Blink: with `BLINK_FRAMES` = 2 and `INVULN_FRAMES` = 6 → `player_visible_out` reads 0,0,1,1,0,0 across the 6 cooldown frames, then 1 on return to ARMED.
- Game over: assert `game_over_in` at PULSE cycle 2 → `damage_out` is 0 from the next cycle. Further overlaps over 5 frames give no pulse, `hit_count_out` holds, and only `rst` restores ARMED.
- Saturation and reset: drive 9 hits with `INVULN_FRAMES` = 1 → `hit_count_out` stops at 7. Assert `rst` mid-COOLDOWN → ARMED on the next cycle, and an overlap in that same frame produces a pulse at the next `fb`.

Source files
------------

// File: rtl/hit_detector_if.sv
// hit_detector_if: pixel position, sprite flags and game-over level going
// into the hit detector, plus the damage/invulnerability/blink/hit-count
// results coming back out.
//   master : drives the pixel/sprite/game-over side, reads the results
//   slave  : the hit detector itself
interface hit_detector_if;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        player_in_sprite;
  logic        hazard_in_sprite;
  logic        game_over_in;
  logic        damage_out;
  logic        invuln_out;
  logic        player_visible_out;
  logic [2:0]  hit_count_out;

  modport master (
    output hcount_in, vcount_in, player_in_sprite, hazard_in_sprite, game_over_in,
    input  damage_out, invuln_out, player_visible_out, hit_count_out
  );

  modport slave (
    input  hcount_in, vcount_in, player_in_sprite, hazard_in_sprite, game_over_in,
    output damage_out, invuln_out, player_visible_out, hit_count_out
  );
endinterface

// File: rtl/hit_detector.sv
// hit_detector: latches player/hazard sprite overlap inside the active area,
// emits one damage pulse at the end of the frame that saw it, then holds an
// invulnerability window (with player blinking) for a fixed number of frames.
// Freezes in DEAD once game over is signalled, until reset.
// Ports:
//   clk  - pixel clock
//   rst  - synchronous active-high reset
//   bus  - hit_detector_if.slave: hcount/vcount, sprite flags, game_over_in
//          in; damage_out, invuln_out, player_visible_out, hit_count_out out
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ARMED    | watching for overlap; latched hit fires at frame boundary
// PULSE    | damage_out high for PULSE_CYCLES clocks
// COOLDOWN | invulnerable for INVULN_FRAMES frames, player blinks
// DEAD     | game over; outputs frozen until reset
module hit_detector #(
  parameter int ACTIVE_H      = 1280,
  parameter int ACTIVE_V      = 720,
  parameter int PULSE_CYCLES  = 4,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_FRAMES  = 8
) (
  input logic           clk,
  input logic           rst,
  hit_detector_if.slave bus
);

  typedef enum logic [1:0] {
    S_ARMED,
    S_PULSE,
    S_COOLDOWN,
    S_DEAD
  } state_t;

  localparam logic [10:0] H_LIM      = 11'(ACTIVE_H);
  localparam logic [9:0]  V_LIM      = 10'(ACTIVE_V);
  localparam logic [7:0]  PULSE_LD   = 8'(PULSE_CYCLES);
  localparam logic [7:0]  INVULN_LD  = 8'(INVULN_FRAMES);
  localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);

  state_t     state, state_n;
  logic [7:0] pulse_cnt, pulse_cnt_n;
  logic [7:0] frame_cnt, frame_cnt_n;
  logic [7:0] blink_cnt, blink_cnt_n;
  logic       hit_latched, hit_latched_n;
  logic       visible, visible_n;
  logic [2:0] hit_count, hit_count_n;
  logic       damage, invuln;
  logic       damage_n, invuln_n;

  logic fb;
  logic overlap;

  // The frame boundary sits at vcount == ACTIVE_V, which is outside the
  // active area, so fb and overlap are mutually exclusive by construction.
  assign fb      = (bus.hcount_in == 11'd0) && (bus.vcount_in == V_LIM);
  assign overlap = bus.player_in_sprite && bus.hazard_in_sprite &&
                   (bus.hcount_in < H_LIM) && (bus.vcount_in < V_LIM);

  always_comb begin
    state_n       = state;
    pulse_cnt_n   = pulse_cnt;
    frame_cnt_n   = frame_cnt;
    blink_cnt_n   = blink_cnt;
    hit_latched_n = hit_latched;
    visible_n     = visible;
    hit_count_n   = hit_count;

    if (bus.game_over_in) begin
      // Wins over a hit pending at the same boundary: that hit is dropped.
      state_n       = S_DEAD;
      hit_latched_n = 1'b0;
      visible_n     = 1'b1;
    end else begin
      case (state)
        S_ARMED: begin
          if (fb) begin
            if (hit_latched) begin
              state_n       = S_PULSE;
              pulse_cnt_n   = PULSE_LD;
              hit_latched_n = 1'b0;
              if (hit_count != 3'd7) hit_count_n = hit_count + 3'd1;
            end
          end else if (overlap) begin
            hit_latched_n = 1'b1;
          end
        end
        S_PULSE: begin
          if (pulse_cnt <= 8'd1) begin
            pulse_cnt_n = 8'd0;
            state_n     = S_COOLDOWN;
            frame_cnt_n = INVULN_LD;
            blink_cnt_n = 8'd0;
            visible_n   = 1'b0;
          end else begin
            pulse_cnt_n = pulse_cnt - 8'd1;
          end
        end
        S_COOLDOWN: begin
          hit_latched_n = 1'b0;
          if (fb) begin
            frame_cnt_n = frame_cnt - 8'd1;
            if (blink_cnt >= BLINK_LAST) begin
              blink_cnt_n = 8'd0;
              visible_n   = ~visible;
            end else begin
              blink_cnt_n = blink_cnt + 8'd1;
            end
            if (frame_cnt <= 8'd1) begin
              frame_cnt_n = 8'd0;
              state_n     = S_ARMED;
              visible_n   = 1'b1;
            end
          end
        end
        S_DEAD: begin
          hit_latched_n = 1'b0;
          visible_n     = 1'b1;
        end
        default: state_n = S_ARMED;
      endcase
    end

    // Outputs are registered copies of what the next state implies, so
    // damage/invuln line up with the state they describe.
    damage_n = (state_n == S_PULSE);
    invuln_n = (state_n == S_PULSE) || (state_n == S_COOLDOWN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_ARMED;
      pulse_cnt   <= 8'd0;
      frame_cnt   <= 8'd0;
      blink_cnt   <= 8'd0;
      hit_latched <= 1'b0;
      visible     <= 1'b1;
      hit_count   <= 3'd0;
      damage      <= 1'b0;
      invuln      <= 1'b0;
    end else begin
      state       <= state_n;
      pulse_cnt   <= pulse_cnt_n;
      frame_cnt   <= frame_cnt_n;
      blink_cnt   <= blink_cnt_n;
      hit_latched <= hit_latched_n;
      visible     <= visible_n;
      hit_count   <= hit_count_n;
      damage      <= damage_n;
      invuln      <= invuln_n;
    end
  end

  assign bus.damage_out         = damage;
  assign bus.invuln_out         = invuln;
  assign bus.player_visible_out = visible;
  assign bus.hit_count_out      = hit_count;

endmodule
